// File: rtl/parity_pkg.sv
// Shared encodings for the odd-parity serial transmitter.
package parity_pkg;

    // Frame sequencing states (3-bit encoding).
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Level the serial line rests at between frames (and during the stop bit).
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_tick_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
module bit_tick_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick_last
);

    // A single-cycle bit still gets a 1-bit counter that simply stays at zero.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Restart on every bit boundary or while held clear, otherwise advance.
    always_ff @(posedge clk) begin
        if (rst || clear) r_cnt <= '0;
        else              r_cnt <= r_cnt + 1'b1;
    end

    assign tick_last = (r_cnt == LAST);

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Serial frame transmitter: start bit, DATA_W bits LSB-first, odd parity, stop bit.
module odd_parity_serial_tx
    import parity_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              parity_out
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [BIT_W-1:0]  r_bit, w_bit_nxt;
    logic              r_parity, w_parity_nxt;
    logic              r_tx, w_tx_nxt;
    logic              r_busy, r_ready, r_done, w_done_nxt;
    logic              w_accept, w_tick_last, w_tick_clear;

    // Counter idles at zero and restarts each time a bit period ends.
    assign w_tick_clear = (r_state == ST_IDLE) || w_tick_last;

    bit_tick_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_tick_clear),
        .tick_last (w_tick_last)
    );

    // Next-state, shift/bit-index updates, and the next registered output values.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bit_nxt    = r_bit;
        w_parity_nxt = r_parity;
        w_done_nxt   = 1'b0;
        w_accept     = in_valid && r_ready;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ST_START;
                    w_shift_nxt  = in_data;
                    w_parity_nxt = ~(^in_data);
                    w_bit_nxt    = '0;
                end
            end
            ST_START: begin
                if (w_tick_last) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick_last) begin
                    if (r_bit == LAST_BIT) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick_last) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Line level is decided from the state being entered so tx is a plain flop.
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
            ST_PARITY: w_tx_nxt = w_parity_nxt;
            default:   w_tx_nxt = IDLE_LEVEL;
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bit    <= '0;
            r_parity <= 1'b0;
            r_tx     <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bit    <= w_bit_nxt;
            r_parity <= w_parity_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_ready  <= (w_state_nxt == ST_IDLE);
            r_done   <= w_done_nxt;
        end
    end

    assign in_ready   = r_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign parity_out = r_parity;

endmodule

// File: doc/odd_parity_serial_tx.md
Name: odd_parity_serial_tx

Overview:
- Serial frame transmitter that sequences an odd-parity bit into a start/data/parity/stop frame.
- Accepts one DATA_W-bit word per valid/ready handshake and drives it LSB-first on a single idle-high line.
- Appends a parity bit computed so that data bits plus parity bit contain an odd number of ones.
- Sits between the lab's word-producing logic and any serial sink (UART-style receiver, checker, scope pin).

Parameters:
DATA_W, 8, data bits per frame (legal 1..16)
CLKS_PER_BIT, 4, clk cycles each serial bit is held (legal 1..1024)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data holds a word to send
in_data  input  DATA_W  word to transmit
in_ready  output  1  block can accept a word this cycle
tx  output  1  serial line; idles high
busy  output  1  frame in progress
done  output  1  one-cycle pulse when the stop bit completes
parity_out  output  1  parity bit of the word currently or last sent

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, tx=1, busy=0, done=0, in_ready=1, parity_out=0, bit/tick counters=0. Takes effect on the next edge from any state. A frame interrupted by reset is abandoned, not resumed.
- Handshake: transfer occurs on a cycle with in_valid && in_ready.
  - in_ready = (state==IDLE).
  - On transfer, latch in_data into the shift register and register parity_out = ~(^in_data).
  - Go to START. in_data may change freely afterwards.
- States:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx=shift[0]. Shift right once per bit period. Bit index counts 0..DATA_W-1.
  - PARITY: tx=parity_out.
  - STOP: tx=1.
- Bit timing:
  - Tick counter counts 0..CLKS_PER_BIT-1 in every non-IDLE state and clears on each state or bit change.
  - Each bit is held exactly CLKS_PER_BIT cycles.
- Transitions occur when the tick counter is at CLKS_PER_BIT-1:
  - START->DATA.
  - DATA->DATA while bit index < DATA_W-1, otherwise DATA->PARITY.
  - PARITY->STOP.
  - STOP->IDLE.
- Latency:
  - tx first goes low on the edge after the handshake.
  - Frame length is (DATA_W+3)*CLKS_PER_BIT cycles.
  - done=1 for exactly one cycle, the first cycle back in IDLE.
- Back-to-back: in_ready is 1 in that same IDLE cycle, so a new word can be accepted while done=1. A continuously valid source gets one idle-high cycle between frames.
- busy = (state != IDLE). All outputs are registered. tx has no combinational path from inputs.
- in_valid while busy is ignored; the word is not lost because in_ready=0 and the source holds it.
- Counters are sized with $clog2. The CLKS_PER_BIT=1 case must work: one cycle per bit, no zero-width counter.
- parity_out keeps its value after the frame until the next accepted word.

Decomposition:
- Shared package/header `parity_pkg`:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP as 3-bit localparams)
  - an IDLE_LEVEL=1 constant
- One natural sub-module, `bit_tick_counter` (CLKS_PER_BIT parameter; clk, rst, clear, tick_last out). It is instantiated once for the bit-period timing.
- Parity is a single reduction-XNOR inline; it needs no sub-module.

Test Plan:
- Reset with DATA_W=8, CLKS_PER_BIT=4: hold rst 2 cycles mid-frame -> next edge tx=1, busy=0, in_ready=1, done=0; no further toggles on tx.
- Send 0x01 -> frame sampled every 4 cycles reads 0,1,0,0,0,0,0,0,0,0,1 (start, LSB-first data, parity=0, stop); done pulses at cycle 44 after the handshake; parity_out=0.
- Send 0x00, then 0xFF -> parity bit 1 for both (0 ones and 8 ones, both even); parity_out=1.
- Hold in_valid high with 0xA5 then 0x3C -> exactly one idle-high cycle between frames; in_ready and done both high in that cycle; parity bits 1 and 1; no word dropped or duplicated.
- Toggle in_data and in_valid randomly while busy=1 -> transmitted bits match the latched word only; in_ready stays 0 until done.
- CLKS_PER_BIT=1, DATA_W=4, send 0x7 -> tx sequence 0,1,1,1,0,0,1 on consecutive cycles; done on cycle 7 after the handshake.
